alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It has operand width `WIDTH`, registered results and flags, and valid/ready handshakes on both sides. It adds multi-cycle full-width multiply and unsigned divide, implemented as shift-add and restoring division. It sits between the register-file read stage and write-back, and stalls the issuing stage while a multi-cycle operation runs.

---
 rtl/alu_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Handshaked, parametrised ALU sitting between register-file read and
// write-back. Single-cycle operations are computed at accept time and
// presented on the next cycle. Full-width multiply (shift-add) and unsigned
// divide (restoring) iterate for WIDTH cycles, during which the issuing stage
// is stalled because in_ready_o is low outside IDLE.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous, active-high reset
//   in_valid_i   : operands/opcode valid
//   in_ready_o   : block accepts an operation (IDLE only)
//   a_i, b_i     : unsigned operands, WIDTH bits
//   opcode_i     : 4-bit operation select
//   out_valid_o  : result and flags valid, held until accepted
//   out_ready_i  : consumer accepts the result
//   result_o     : result / product low half / quotient
//   result_hi_o  : product high half / remainder, else 0
//   zero_o       : result_o and result_hi_o both zero
//   carry_o      : carry, borrow, shift-out, overflow or div-by-zero
//   busy_o       : multi-cycle operation in progress
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       opcode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_EQ   = 4'b0110;
  localparam logic [3:0] OP_GTU  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MULL = 4'b1010;
  localparam logic [3:0] OP_MULW = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_ROL  = 4'b1101;
  localparam logic [3:0] OP_ROR  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [CW-1:0]    count_q,    count_d;
  logic             isDiv_q,    isDiv_d;
  logic [WIDTH-1:0] opB_q,      opB_d;
  logic [WIDTH-1:0] accHi_q,    accHi_d;
  logic [WIDTH-1:0] accLo_q,    accLo_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic [WIDTH-1:0] resultHi_q, resultHi_d;
  logic             zero_q,     zero_d;
  logic             carry_q,    carry_d;

  logic [WIDTH-1:0] aluLo;
  logic             aluCarry;
  logic [WIDTH:0]   aluSum;
  logic [WIDTH-1:0] aluMul;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHiNext;
  logic [WIDTH-1:0] mulLoNext;
  logic [WIDTH:0]   divShift;
  logic             divGe;
  logic [WIDTH-1:0] divDiff;
  logic [WIDTH-1:0] divRemNext;
  logic [WIDTH-1:0] divQuotNext;
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;

  // Single-cycle datapath, evaluated straight off the input ports so the
  // answer can be registered at the accepting edge.
  always_comb begin
    aluSum   = {1'b0, a_i} + {1'b0, b_i};
    aluMul   = a_i * b_i;
    aluLo    = '0;
    aluCarry = 1'b0;
    unique case (opcode_i)
      OP_ADD: begin
        aluLo    = aluSum[WIDTH-1:0];
        aluCarry = aluSum[WIDTH];
      end
      OP_SUB: begin
        aluLo    = a_i - b_i;
        aluCarry = (a_i < b_i);
      end
      OP_AND:  aluLo = a_i & b_i;
      OP_OR:   aluLo = a_i | b_i;
      OP_XOR:  aluLo = a_i ^ b_i;
      OP_NOT:  aluLo = ~a_i;
      OP_EQ:   aluLo = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      OP_GTU:  aluLo = {{(WIDTH-1){1'b0}}, (a_i > b_i)};
      OP_SHL: begin
        aluLo    = {a_i[WIDTH-2:0], 1'b0};
        aluCarry = a_i[WIDTH-1];
      end
      OP_SHR: begin
        aluLo    = {1'b0, a_i[WIDTH-1:1]};
        aluCarry = a_i[0];
      end
      OP_MULL: aluLo = aluMul;
      OP_ROL: begin
        aluLo    = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
        aluCarry = a_i[WIDTH-1];
      end
      OP_ROR: begin
        aluLo    = {a_i[0], a_i[WIDTH-1:1]};
        aluCarry = a_i[0];
      end
      default: begin
        aluLo    = '0;
        aluCarry = 1'b0;
      end
    endcase
  end

  // One iteration of the multi-cycle engines. Multiply keeps the partial
  // product in accHi and the not-yet-consumed multiplier bits in accLo; each
  // step conditionally adds the multiplicand and shifts the pair right.
  // Divide keeps the partial remainder in accHi and shifts the dividend out
  // of accLo while quotient bits shift in from the bottom. With a zero
  // divisor every trial subtraction succeeds, which naturally yields an
  // all-ones quotient and leaves the dividend as the remainder.
  always_comb begin
    mulSum      = accLo_q[0] ? ({1'b0, accHi_q} + {1'b0, opB_q}) : {1'b0, accHi_q};
    mulHiNext   = mulSum[WIDTH:1];
    mulLoNext   = {mulSum[0], accLo_q[WIDTH-1:1]};

    divShift    = {accHi_q, accLo_q[WIDTH-1]};
    divGe       = (divShift >= {1'b0, opB_q});
    // When divGe holds the true difference is below opB_q, so the low
    // WIDTH bits of the subtraction are exact.
    divDiff     = divShift[WIDTH-1:0] - opB_q;
    divRemNext  = divGe ? divDiff : divShift[WIDTH-1:0];
    divQuotNext = {accLo_q[WIDTH-2:0], divGe};

    stepHi      = isDiv_q ? divRemNext  : mulHiNext;
    stepLo      = isDiv_q ? divQuotNext : mulLoNext;
  end

  // Next-state logic. Everything holds by default; the result registers
  // only change at the accept of a single-cycle op or on the final
  // iteration, which keeps them stable for as long as DONE is back-pressured.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    isDiv_d    = isDiv_q;
    opB_d      = opB_q;
    accHi_d    = accHi_q;
    accLo_d    = accLo_q;
    result_d   = result_q;
    resultHi_d = resultHi_q;
    zero_d     = zero_q;
    carry_d    = carry_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if ((opcode_i == OP_MULW) || (opcode_i == OP_DIVU)) begin
            state_d = CALC;
            count_d = CW'(WIDTH);
            isDiv_d = (opcode_i == OP_DIVU);
            opB_d   = (opcode_i == OP_DIVU) ? b_i : a_i;
            accHi_d = '0;
            accLo_d = (opcode_i == OP_DIVU) ? a_i : b_i;
          end else begin
            state_d    = DONE;
            result_d   = aluLo;
            resultHi_d = '0;
            zero_d     = (aluLo == '0);
            carry_d    = aluCarry;
          end
        end
      end
      CALC: begin
        accHi_d = stepHi;
        accLo_d = stepLo;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d    = DONE;
          result_d   = stepLo;
          resultHi_d = stepHi;
          zero_d     = ({stepHi, stepLo} == '0);
          carry_d    = isDiv_q ? (opB_q == '0) : (stepHi != '0);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      isDiv_q    <= 1'b0;
      opB_q      <= '0;
      accHi_q    <= '0;
      accLo_q    <= '0;
      result_q   <= '0;
      resultHi_q <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      isDiv_q    <= isDiv_d;
      opB_q      <= opB_d;
      accHi_q    <= accHi_d;
      accLo_q    <= accLo_d;
      result_q   <= result_d;
      resultHi_q <= resultHi_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
    end
  end

  // Handshake and status outputs are pure decodes of the state register.
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == CALC);
  assign result_o    = result_q;
  assign result_hi_o = resultHi_q;
  assign zero_o      = zero_q;
  assign carry_o     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//
// Drives an 8-bit and a 16-bit alu_seq with directed and random operations
// and compares every output against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v8, rdy8, ov8, ordy8, z8, c8, bz8;
  logic [7:0]  a8, b8, r8, rh8;
  logic [3:0]  op8;

  logic        v16, rdy16, ov16, ordy16, z16, c16, bz16;
  logic [15:0] a16, b16, r16, rh16;
  logic [3:0]  op16;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v8), .in_ready_o(rdy8),
    .a_i(a8), .b_i(b8), .opcode_i(op8), .out_valid_o(ov8),
    .out_ready_i(ordy8), .result_o(r8), .result_hi_o(rh8),
    .zero_o(z8), .carry_o(c8), .busy_o(bz8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v16), .in_ready_o(rdy16),
    .a_i(a16), .b_i(b16), .opcode_i(op16), .out_valid_o(ov16),
    .out_ready_i(ordy16), .result_o(r16), .result_hi_o(rh16),
    .zero_o(z16), .carry_o(c16), .busy_o(bz16)
  );

  // Reference model straight from the operation table, using wide integer
  // arithmetic and masking to the operand width.
  function automatic void model(input int w, input int op,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned lo, output longint unsigned hi,
                                output bit c);
    longint unsigned mask;
    longint unsigned p;
    mask = (64'd1 << w) - 64'd1;
    lo = 0; hi = 0; c = 1'b0;
    case (op)
      0:  begin p = a + b; lo = p & mask; c = ((p >> w) & 1) != 0; end
      1:  begin lo = (a - b) & mask; c = (a < b); end
      2:  lo = a & b;
      3:  lo = a | b;
      4:  lo = a ^ b;
      5:  lo = (~a) & mask;
      6:  lo = (a == b) ? 1 : 0;
      7:  lo = (a > b) ? 1 : 0;
      8:  begin lo = (a << 1) & mask; c = ((a >> (w - 1)) & 1) != 0; end
      9:  begin lo = a >> 1; c = (a & 1) != 0; end
      10: lo = (a * b) & mask;
      11: begin p = a * b; lo = p & mask; hi = p >> w; c = (hi != 0); end
      12: begin
        if (b == 0) begin lo = mask; hi = a; c = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
      13: begin lo = ((a << 1) | (a >> (w - 1))) & mask; c = ((a >> (w - 1)) & 1) != 0; end
      14: begin lo = ((a >> 1) | ((a & 1) << (w - 1))) & mask; c = (a & 1) != 0; end
      default: begin lo = 0; hi = 0; c = 1'b0; end
    endcase
  endfunction

  function automatic logic [15:0] getResult(input int w);
    return (w == 8) ? {8'h00, r8} : r16;
  endfunction

  function automatic logic [15:0] getHi(input int w);
    return (w == 8) ? {8'h00, rh8} : rh16;
  endfunction

  // {in_ready, out_valid, busy, zero, carry}
  function automatic logic [4:0] getFlags(input int w);
    return (w == 8) ? {rdy8, ov8, bz8, z8, c8} : {rdy16, ov16, bz16, z16, c16};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveInputs(input int w, input logic valid, input logic [3:0] op,
                             input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      v8 = valid; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      v16 = valid; op16 = op; a16 = a; b16 = b;
    end
  endtask

  task automatic driveReady(input int w, input logic rdy);
    if (w == 8) ordy8 = rdy;
    else        ordy16 = rdy;
  endtask

  // Issue one operation, measure latency and busy time, hold back-pressure
  // for `hold` cycles while checking stability, then hand the result off.
  task automatic applyStimulus(input int w, input int op, input logic [15:0] a,
                               input logic [15:0] b, input int hold);
    longint unsigned eLo, eHi;
    bit eC;
    bit eZero;
    int expLat, expBusy, edges, busyCnt;
    logic [4:0] f;
    string t;
    longint unsigned mask;
    mask = (64'd1 << w) - 64'd1;
    model(w, op, longint'(a) & mask, longint'(b) & mask, eLo, eHi, eC);
    eZero   = ((eLo | eHi) == 0);
    expLat  = (op == 11 || op == 12) ? w + 1 : 1;
    expBusy = (op == 11 || op == 12) ? w : 0;
    t = $sformatf("w%0d op%0h a%0h b%0h", w, op, a, b);

    @(negedge clk);
    f = getFlags(w);
    checkOutput({t, " in_ready_idle"}, 16'(f[4]), 16'd1);
    driveReady(w, 1'b0);
    driveInputs(w, 1'b1, 4'(op), a, b);
    @(negedge clk);
    // Operands are don't-care after accept; scramble them.
    driveInputs(w, 1'b0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    edges = 1;
    busyCnt = 0;
    while (!getFlags(w)[3] && edges < 100) begin
      if (getFlags(w)[2]) busyCnt++;
      @(negedge clk);
      edges++;
    end
    checkOutput({t, " out_valid"}, 16'(getFlags(w)[3]), 16'd1);
    checkOutput({t, " latency"}, 16'(edges), 16'(expLat));
    checkOutput({t, " busy_cycles"}, 16'(busyCnt), 16'(expBusy));
    for (int i = 0; i <= hold; i++) begin
      f = getFlags(w);
      checkOutput({t, " result"}, getResult(w), 16'(eLo));
      checkOutput({t, " result_hi"}, getHi(w), 16'(eHi));
      checkOutput({t, " zero"}, 16'(f[1]), 16'(eZero));
      checkOutput({t, " carry"}, 16'(f[0]), 16'(eC));
      checkOutput({t, " in_ready_done"}, 16'(f[4]), 16'd0);
      checkOutput({t, " valid_held"}, 16'(f[3]), 16'd1);
      if (i < hold) @(negedge clk);
    end
    driveReady(w, 1'b1);
    @(negedge clk);
    driveReady(w, 1'b0);
    f = getFlags(w);
    checkOutput({t, " handoff_valid"}, 16'(f[3]), 16'd0);
    checkOutput({t, " handoff_ready"}, 16'(f[4]), 16'd1);
  endtask

  initial begin
    logic [4:0] f;
    rst = 1'b1;
    driveInputs(8, 1'b0, 4'd0, 16'd0, 16'd0);
    driveInputs(16, 1'b0, 4'd0, 16'd0, 16'd0);
    ordy8 = 1'b0;
    ordy16 = 1'b0;
    repeat (2) @(negedge clk);

    for (int w = 8; w <= 16; w += 8) begin
      f = getFlags(w);
      checkOutput($sformatf("w%0d reset in_ready", w), 16'(f[4]), 16'd1);
      checkOutput($sformatf("w%0d reset out_valid", w), 16'(f[3]), 16'd0);
      checkOutput($sformatf("w%0d reset busy", w), 16'(f[2]), 16'd0);
      checkOutput($sformatf("w%0d reset zero", w), 16'(f[1]), 16'd0);
      checkOutput($sformatf("w%0d reset carry", w), 16'(f[0]), 16'd0);
      checkOutput($sformatf("w%0d reset result", w), getResult(w), 16'd0);
      checkOutput($sformatf("w%0d reset result_hi", w), getHi(w), 16'd0);
    end
    rst = 1'b0;

    $display("[TB] directed 8-bit operations");
    applyStimulus(8, 0, 16'd200, 16'd100, 0);
    applyStimulus(8, 1, 16'd5, 16'd7, 0);
    applyStimulus(8, 1, 16'd9, 16'd9, 0);
    applyStimulus(8, 11, 16'd200, 16'd3, 0);
    applyStimulus(8, 12, 16'd200, 16'd7, 0);
    applyStimulus(8, 12, 16'd200, 16'd0, 1);
    applyStimulus(8, 8, 16'h81, 16'h00, 5);
    applyStimulus(8, 15, 16'h5A, 16'hA5, 0);
    applyStimulus(8, 6, 16'h00, 16'h00, 0);

    $display("[TB] random 8-bit operations");
    for (int i = 0; i < 48; i++) begin
      applyStimulus(8, int'($urandom_range(0, 15)), 16'($urandom_range(0, 255)),
                    16'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("[TB] reset during DIVU");
    @(negedge clk);
    driveInputs(8, 1'b1, 4'd12, 16'd200, 16'd7);
    @(negedge clk);
    driveInputs(8, 1'b0, 4'd0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort busy_before_reset", 16'(bz8), 16'd1);
    rst = 1'b1;
    #1;
    f = getFlags(8);
    checkOutput("abort in_ready", 16'(f[4]), 16'd1);
    checkOutput("abort out_valid", 16'(f[3]), 16'd0);
    checkOutput("abort busy", 16'(f[2]), 16'd0);
    checkOutput("abort zero", 16'(f[1]), 16'd0);
    checkOutput("abort carry", 16'(f[0]), 16'd0);
    checkOutput("abort result", getResult(8), 16'd0);
    checkOutput("abort result_hi", getHi(8), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abort no_late_output", 16'(ov8), 16'd0);
    checkOutput("abort idle_after", 16'(rdy8), 16'd1);

    $display("[TB] 16-bit operations");
    applyStimulus(16, 11, 16'hFFFF, 16'hFFFF, 0);
    applyStimulus(16, 12, 16'd54321, 16'd123, 0);
    applyStimulus(16, 12, 16'hBEEF, 16'd0, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16, int'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
